// File: rtl/fetch_ctrl_pkg.sv
// Shared widths, reset/trap vectors and FSM state encoding for the fetch sequencer.
package fetch_ctrl_pkg;

    localparam int          DEF_ADDR_LEN  = 32;
    localparam int          DEF_DATA_LEN  = 32;
    localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] DEF_TRAP_VEC  = 32'h0000_0004;

    typedef enum logic [1:0] {
        FS_BOOT  = 2'd0,
        FS_REQ   = 2'd1,
        FS_VALID = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_next_pc.sv
// Next-PC priority mux: trap > redirect > pc+4, with word alignment of redirect targets.
module fetch_next_pc
    import fetch_ctrl_pkg::*;
#(
    parameter int                  ADDR_LEN = DEF_ADDR_LEN,
    parameter logic [ADDR_LEN-1:0] TRAP_VEC = DEF_TRAP_VEC
) (
    input  logic [ADDR_LEN-1:0] pc,
    input  logic                trap,
    input  logic                redirect_valid,
    input  logic [ADDR_LEN-1:0] redirect_pc,
    output logic [ADDR_LEN-1:0] next_pc,
    output logic                flow_change,
    output logic                misalign
);

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        next_pc     = pc + ADDR_LEN'(4);
        misalign    = 1'b0;
        flow_change = trap | redirect_valid;
        if (trap) begin
            next_pc = TRAP_VEC;
        end else if (redirect_valid) begin
            next_pc  = {redirect_pc[ADDR_LEN-1:2], 2'b00};
            misalign = |redirect_pc[1:0];
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, runs one req/ack fetch at a time and
// holds the fetched instruction for decode; flow changes during a fetch are deferred.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int                  ADDR_LEN  = DEF_ADDR_LEN,
    parameter int                  DATA_LEN  = DEF_DATA_LEN,
    parameter logic [ADDR_LEN-1:0] RESET_VEC = DEF_RESET_VEC,
    parameter logic [ADDR_LEN-1:0] TRAP_VEC  = DEF_TRAP_VEC
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                redirect_valid,
    input  logic [ADDR_LEN-1:0] redirect_pc,
    input  logic                trap,
    input  logic                stall,
    output logic                imem_req,
    output logic [ADDR_LEN-1:0] imem_addr,
    input  logic                imem_ack,
    input  logic [DATA_LEN-1:0] imem_rdata,
    output logic                inst_valid,
    output logic [DATA_LEN-1:0] inst,
    output logic [ADDR_LEN-1:0] inst_pc,
    output logic [ADDR_LEN-1:0] pc,
    output logic                misalign
);

    fetch_state_e        state_q, state_d;
    logic [ADDR_LEN-1:0] pc_q, pc_d;
    logic [ADDR_LEN-1:0] target_q, target_d;
    logic                kill_q, kill_d;
    logic                req_q, req_d;
    logic                valid_q, valid_d;
    logic [DATA_LEN-1:0] inst_q, inst_d;
    logic [ADDR_LEN-1:0] inst_pc_q, inst_pc_d;
    logic                mis_q, mis_d;

    logic [ADDR_LEN-1:0] np;
    logic                flow_change;
    logic                np_misalign;

    fetch_next_pc #(
        .ADDR_LEN (ADDR_LEN),
        .TRAP_VEC (TRAP_VEC)
    ) u_next_pc (
        .pc             (pc_q),
        .trap           (trap),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .next_pc        (np),
        .flow_change    (flow_change),
        .misalign       (np_misalign)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        target_d  = target_q;
        kill_d    = kill_q;
        req_d     = req_q;
        valid_d   = valid_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        mis_d     = 1'b0;

        unique case (state_q)
            FS_BOOT: begin
                if (flow_change) begin
                    pc_d  = np;
                    mis_d = np_misalign;
                end
                state_d = FS_REQ;
                req_d   = 1'b1;
            end
            FS_REQ: begin
                if (imem_ack) begin
                    if (kill_q || flow_change) begin
                        // Stale data: restart at the newest target, request stays up.
                        pc_d   = flow_change ? np : target_q;
                        mis_d  = np_misalign;
                        kill_d = 1'b0;
                    end else begin
                        inst_d    = imem_rdata;
                        inst_pc_d = pc_q;
                        valid_d   = 1'b1;
                        req_d     = 1'b0;
                        state_d   = FS_VALID;
                    end
                end else if (flow_change) begin
                    kill_d   = 1'b1;
                    target_d = np;
                    mis_d    = np_misalign;
                end
            end
            FS_VALID: begin
                if (flow_change || !stall) begin
                    pc_d    = np;
                    mis_d   = np_misalign;
                    valid_d = 1'b0;
                    req_d   = 1'b1;
                    state_d = FS_REQ;
                end
            end
            default: begin
                state_d = FS_BOOT;
                req_d   = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            state_q   <= FS_BOOT;
            pc_q      <= RESET_VEC;
            target_q  <= '0;
            kill_q    <= 1'b0;
            req_q     <= 1'b0;
            valid_q   <= 1'b0;
            // NOTE: the instruction holding register is reset too, since its value is visible at the port.
            inst_q    <= '0;
            inst_pc_q <= '0;
            mis_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            target_q  <= target_d;
            kill_q    <= kill_d;
            req_q     <= req_d;
            valid_q   <= valid_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            mis_q     <= mis_d;
        end
    end

    assign imem_req   = req_q;
    assign imem_addr  = pc_q;
    assign inst_valid = valid_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign pc         = pc_q;
    assign misalign   = mis_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed cycle table, then randomized fetch traffic
// checked against a transaction-level PC model.
module tb_fetch_ctrl;
    import fetch_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        trap = 1'b0;
    logic        stall = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] pc;
    logic        misalign;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fetch_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .trap           (trap),
        .stall          (stall),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .pc             (pc),
        .misalign       (misalign)
    );

    typedef struct {
        logic        rst_n, stall, rv;
        logic [31:0] rpc;
        logic        trap, ack;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_pc;
        logic        e_valid;
        logic [31:0] e_inst, e_ipc;
        logic        e_mis;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [31:0] mw(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1234_5678;
    endfunction

    function automatic vec_t v(input logic r, input logic s, input logic rv, input logic [31:0] rpc,
                               input logic t, input logic ack, input logic [31:0] rd,
                               input logic e_req, input logic [31:0] e_pc, input logic e_valid,
                               input logic [31:0] e_inst, input logic [31:0] e_ipc, input logic e_mis);
        vec_t x;
        x.rst_n = r; x.stall = s; x.rv = rv; x.rpc = rpc; x.trap = t; x.ack = ack; x.rdata = rd;
        x.e_req = e_req; x.e_pc = e_pc; x.e_valid = e_valid; x.e_inst = e_inst; x.e_ipc = e_ipc;
        x.e_mis = e_mis;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs;
        redirect_valid = 1'b0;
        trap           = 1'b0;
        stall          = 1'b0;
        imem_ack       = 1'b0;
        redirect_pc    = '0;
        imem_rdata     = '0;
    endtask

    localparam logic [31:0] JUNK = 32'hDEAD_BEEF;
    localparam logic [31:0] TOP  = 32'hFFFF_FFFC;

    logic [31:0] exp_pc;
    logic [31:0] tgt;
    logic        exp_mis;
    int          k, act, lat;

    initial begin
        //        rst s rv rpc           t ack rdata        req pc        vld inst         ipc   mis
        tbl.push_back(v(0,0,0,0,          0,0,0,           0,0,          0,0,           0,    0)); // 0 reset
        tbl.push_back(v(1,0,0,0,          0,0,0,           1,0,          0,0,           0,    0)); // 1 boot
        tbl.push_back(v(1,0,0,0,          0,0,0,           1,0,          0,0,           0,    0));
        tbl.push_back(v(1,0,0,0,          0,1,mw(0),       0,0,          1,mw(0),       0,    0)); // 3 ack
        tbl.push_back(v(1,0,0,0,          0,0,0,           1,4,          0,mw(0),       0,    0));
        tbl.push_back(v(1,0,0,0,          0,0,0,           1,4,          0,mw(0),       0,    0));
        tbl.push_back(v(1,0,0,0,          0,1,mw(4),       0,4,          1,mw(4),       4,    0));
        tbl.push_back(v(1,1,0,0,          0,0,0,           0,4,          1,mw(4),       4,    0)); // 7 stall x3
        tbl.push_back(v(1,1,0,0,          0,0,0,           0,4,          1,mw(4),       4,    0));
        tbl.push_back(v(1,1,0,0,          0,0,0,           0,4,          1,mw(4),       4,    0));
        tbl.push_back(v(1,0,0,0,          0,0,0,           1,8,          0,mw(4),       4,    0));
        tbl.push_back(v(1,0,0,0,          0,1,mw(8),       0,8,          1,mw(8),       8,    0));
        tbl.push_back(v(1,1,1,32'h103,    0,0,0,           1,32'h100,    0,mw(8),       8,    1)); // 12 stalled misaligned redirect
        tbl.push_back(v(1,0,0,0,          0,0,0,           1,32'h100,    0,mw(8),       8,    0));
        tbl.push_back(v(1,0,1,32'h200,    0,0,0,           1,32'h100,    0,mw(8),       8,    0)); // 14 redirect mid-REQ
        tbl.push_back(v(1,0,0,0,          0,0,0,           1,32'h100,    0,mw(8),       8,    0));
        tbl.push_back(v(1,0,0,0,          0,1,JUNK,        1,32'h200,    0,mw(8),       8,    0)); // 16 killed ack
        tbl.push_back(v(1,0,0,0,          0,1,mw(32'h200), 0,32'h200,    1,mw(32'h200), 32'h200, 0));
        tbl.push_back(v(1,0,1,32'h300,    1,0,0,           1,4,          0,mw(32'h200), 32'h200, 0)); // 18 trap beats redirect
        tbl.push_back(v(1,0,0,0,          0,1,mw(4),       0,4,          1,mw(4),       4,    0));
        tbl.push_back(v(1,0,1,TOP,        0,0,0,           1,TOP,        0,mw(4),       4,    0));
        tbl.push_back(v(1,0,0,0,          0,1,mw(TOP),     0,TOP,        1,mw(TOP),     TOP,  0));
        tbl.push_back(v(1,0,0,0,          0,0,0,           1,0,          0,mw(TOP),     TOP,  0)); // 22 wrap
        tbl.push_back(v(1,0,0,0,          0,0,0,           1,0,          0,mw(TOP),     TOP,  0));
        tbl.push_back(v(0,0,0,0,          0,0,0,           0,0,          0,0,           0,    0)); // 24 reset mid-REQ
        tbl.push_back(v(1,0,0,0,          0,1,JUNK,        1,0,          0,0,           0,    0)); // 25 ack in BOOT ignored
        tbl.push_back(v(1,0,0,0,          0,1,mw(0),       0,0,          1,mw(0),       0,    0));
        tbl.push_back(v(1,0,0,0,          0,0,0,           1,4,          0,mw(0),       0,    0));
        tbl.push_back(v(1,0,1,32'h40,     0,1,JUNK,        1,32'h40,     0,mw(0),       0,    0)); // 28 event with ack
        tbl.push_back(v(1,0,0,0,          0,1,mw(32'h40),  0,32'h40,     1,mw(32'h40),  32'h40, 0));
        tbl.push_back(v(0,0,0,0,          0,0,0,           0,0,          0,0,           0,    0)); // 30 reset
        tbl.push_back(v(1,0,1,32'h82,     0,0,0,           1,32'h80,     0,0,           0,    1)); // 31 redirect in BOOT
        tbl.push_back(v(1,0,0,0,          0,1,mw(32'h80),  0,32'h80,     1,mw(32'h80),  32'h80, 0));
        tbl.push_back(v(1,0,0,0,          0,0,0,           1,32'h84,     0,mw(32'h80),  32'h80, 0));
        tbl.push_back(v(1,0,0,0,          1,0,0,           1,32'h84,     0,mw(32'h80),  32'h80, 0)); // 34 trap mid-REQ
        tbl.push_back(v(1,0,1,32'h500,    0,0,0,           1,32'h84,     0,mw(32'h80),  32'h80, 0)); // 35 later redirect wins
        tbl.push_back(v(1,0,0,0,          0,1,JUNK,        1,32'h500,    0,mw(32'h80),  32'h80, 0));
        tbl.push_back(v(1,0,0,0,          0,1,mw(32'h500), 0,32'h500,    1,mw(32'h500), 32'h500, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            rst_n          = tbl[i].rst_n;
            stall          = tbl[i].stall;
            redirect_valid = tbl[i].rv;
            redirect_pc    = tbl[i].rpc;
            trap           = tbl[i].trap;
            imem_ack       = tbl[i].ack;
            imem_rdata     = tbl[i].rdata;
            tick();
            check($sformatf("row%0d imem_req", i), 32'(imem_req), 32'(tbl[i].e_req));
            check($sformatf("row%0d pc", i), pc, tbl[i].e_pc);
            if (tbl[i].e_req)
                check($sformatf("row%0d imem_addr", i), imem_addr, tbl[i].e_pc);
            check($sformatf("row%0d inst_valid", i), 32'(inst_valid), 32'(tbl[i].e_valid));
            check($sformatf("row%0d inst", i), inst, tbl[i].e_inst);
            check($sformatf("row%0d inst_pc", i), inst_pc, tbl[i].e_ipc);
            check($sformatf("row%0d misalign", i), 32'(misalign), 32'(tbl[i].e_mis));
        end
        clear_inputs();

        // Random traffic: model tracks only the architectural next-fetch address.
        exp_pc = 32'h500;
        for (int n = 0; n < 60; n++) begin
            k   = $urandom_range(0, 3);
            act = $urandom_range(0, 5);
            lat = $urandom_range(0, 3);
            tgt = $urandom;
            for (int j = 0; j < k; j++) begin
                stall = 1'b1;
                tick();
                check($sformatf("rnd%0d hold valid", n), 32'(inst_valid), 32'd1);
                check($sformatf("rnd%0d hold inst_pc", n), inst_pc, exp_pc);
                check($sformatf("rnd%0d hold req", n), 32'(imem_req), 32'd0);
            end
            exp_mis = 1'b0;
            if (act == 0) begin
                trap           = 1'b1;
                redirect_valid = $urandom_range(0, 1) != 0;
                redirect_pc    = tgt;
                stall          = $urandom_range(0, 1) != 0;
                exp_pc         = DEF_TRAP_VEC;
            end else if (act == 1) begin
                redirect_valid = 1'b1;
                redirect_pc    = tgt;
                stall          = $urandom_range(0, 1) != 0;
                exp_pc         = tgt & 32'hFFFF_FFFC;
                exp_mis        = tgt[1:0] != 2'b00;
            end else begin
                stall  = 1'b0;
                exp_pc = exp_pc + 32'd4;
            end
            tick();
            clear_inputs();
            check($sformatf("rnd%0d req", n), 32'(imem_req), 32'd1);
            check($sformatf("rnd%0d addr", n), imem_addr, exp_pc);
            check($sformatf("rnd%0d dropped", n), 32'(inst_valid), 32'd0);
            check($sformatf("rnd%0d misalign", n), 32'(misalign), 32'(exp_mis));
            for (int j = 0; j < lat; j++) begin
                tick();
                check($sformatf("rnd%0d wait req", n), 32'(imem_req), 32'd1);
                check($sformatf("rnd%0d wait addr", n), imem_addr, exp_pc);
            end
            imem_ack   = 1'b1;
            imem_rdata = mw(exp_pc);
            tick();
            clear_inputs();
            check($sformatf("rnd%0d valid", n), 32'(inst_valid), 32'd1);
            check($sformatf("rnd%0d inst_pc", n), inst_pc, exp_pc);
            check($sformatf("rnd%0d inst", n), inst, mw(exp_pc));
            check($sformatf("rnd%0d req low", n), 32'(imem_req), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
